// File: rtl/reg_status_file.sv
// Register status file for a ROB-based out-of-order core: committed values plus
// per-register rename state (busy + producing ROB tag), with commit-to-decode forwarding.
module reg_status_file #(
    parameter int ROB_BIT = 4,
    parameter int REG_NUM = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               rob_rb_ena,
    input  logic [4:0]         id_src1,
    input  logic [4:0]         id_src2,
    output logic               id_src1_busy,
    output logic               id_src2_busy,
    output logic [ROB_BIT-1:0] id_src1_tag,
    output logic [ROB_BIT-1:0] id_src2_tag,
    output logic [31:0]        id_val1,
    output logic [31:0]        id_val2,
    input  logic               id_valid,
    input  logic [4:0]         id_dest,
    input  logic [ROB_BIT-1:0] id_rob_idx,
    input  logic               reg_wr_ena,
    input  logic [4:0]         reg_wr_rd,
    input  logic [31:0]        reg_wr_val,
    input  logic [ROB_BIT-1:0] reg_wr_idx
);

    typedef struct packed {
        logic               busy;
        logic [ROB_BIT-1:0] tag;
        logic [31:0]        val;
    } rd_port_t;

    logic [31:0]        val_q  [REG_NUM];
    logic               busy_q [REG_NUM];
    logic [ROB_BIT-1:0] tag_q  [REG_NUM];

    logic commit_en;
    logic commit_match;
    logic issue_en;

    // x0 and indices beyond REG_NUM are never written or renamed.
    assign commit_en    = reg_wr_ena && (reg_wr_rd != 5'd0) && (int'(reg_wr_rd) < REG_NUM);
    assign commit_match = commit_en && (tag_q[reg_wr_rd] == reg_wr_idx);
    assign issue_en     = id_valid && (id_dest != 5'd0) && (int'(id_dest) < REG_NUM) && !rob_rb_ena;

    // A commit in flight is visible to decode in the same cycle; busy only drops
    // when the committing slot is still the register's latest producer.
    function automatic rd_port_t read_src(input logic [4:0] src);
        rd_port_t r;
        r = '0;
        if (src != 5'd0 && int'(src) < REG_NUM) begin
            r.busy = busy_q[src];
            r.tag  = tag_q[src];
            r.val  = val_q[src];
            if (reg_wr_ena && reg_wr_rd == src) begin
                r.val = reg_wr_val;
                if (tag_q[src] == reg_wr_idx) begin
                    r.busy = 1'b0;
                    r.tag  = '0;
                end
            end
        end
        return r;
    endfunction

    assign {id_src1_busy, id_src1_tag, id_val1} = read_src(id_src1);
    assign {id_src2_busy, id_src2_tag, id_val2} = read_src(id_src2);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                val_q[i]  <= '0;
                busy_q[i] <= 1'b0;
                tag_q[i]  <= '0;
            end
        end else if (rdy) begin
            if (rob_rb_ena) begin
                for (int i = 0; i < REG_NUM; i++) begin
                    busy_q[i] <= 1'b0;
                    tag_q[i]  <= '0;
                end
            end else begin
                if (commit_match) begin
                    busy_q[reg_wr_rd] <= 1'b0;
                    tag_q[reg_wr_rd]  <= '0;
                end
                // Placed after the commit clear so a same-register rename wins.
                if (issue_en) begin
                    busy_q[id_dest] <= 1'b1;
                    tag_q[id_dest]  <= id_rob_idx;
                end
            end
            if (commit_en) begin
                val_q[reg_wr_rd] <= reg_wr_val;
            end
        end
    end

endmodule

// File: tb/tb_reg_status_file.sv
// Bench for reg_status_file: directed scenarios with fixed expectations, then random
// traffic compared against a per-register reference model.
module tb_reg_status_file;

    localparam int RB = 4;
    localparam int NR = 32;

    logic          clk;
    logic          rst;
    logic          rdy;
    logic          rob_rb_ena;
    logic [4:0]    id_src1;
    logic [4:0]    id_src2;
    logic          id_src1_busy;
    logic          id_src2_busy;
    logic [RB-1:0] id_src1_tag;
    logic [RB-1:0] id_src2_tag;
    logic [31:0]   id_val1;
    logic [31:0]   id_val2;
    logic          id_valid;
    logic [4:0]    id_dest;
    logic [RB-1:0] id_rob_idx;
    logic          reg_wr_ena;
    logic [4:0]    reg_wr_rd;
    logic [31:0]   reg_wr_val;
    logic [RB-1:0] reg_wr_idx;

    int n_checks;
    int n_errors;

    // Reference model: architectural view of each register.
    logic [31:0]   m_val  [NR];
    logic          m_busy [NR];
    logic [RB-1:0] m_tag  [NR];

    reg_status_file #(.ROB_BIT(RB), .REG_NUM(NR)) dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .rob_rb_ena   (rob_rb_ena),
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_src1_busy (id_src1_busy),
        .id_src2_busy (id_src2_busy),
        .id_src1_tag  (id_src1_tag),
        .id_src2_tag  (id_src2_tag),
        .id_val1      (id_val1),
        .id_val2      (id_val2),
        .id_valid     (id_valid),
        .id_dest      (id_dest),
        .id_rob_idx   (id_rob_idx),
        .reg_wr_ena   (reg_wr_ena),
        .reg_wr_rd    (reg_wr_rd),
        .reg_wr_val   (reg_wr_val),
        .reg_wr_idx   (reg_wr_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_idle();
        rst        = 1'b0;
        rdy        = 1'b1;
        rob_rb_ena = 1'b0;
        id_valid   = 1'b0;
        id_dest    = '0;
        id_rob_idx = '0;
        reg_wr_ena = 1'b0;
        reg_wr_rd  = '0;
        reg_wr_val = '0;
        reg_wr_idx = '0;
    endtask

    task automatic model_update();
        logic commit;
        logic match;
        commit = reg_wr_ena && reg_wr_rd != 0;
        match  = commit && m_tag[reg_wr_rd] == reg_wr_idx;
        if (rst) begin
            for (int i = 0; i < NR; i++) begin
                m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
            end
        end else if (rdy) begin
            if (rob_rb_ena) begin
                for (int i = 0; i < NR; i++) begin
                    m_busy[i] = 1'b0; m_tag[i] = '0;
                end
            end else begin
                if (match) begin
                    m_busy[reg_wr_rd] = 1'b0; m_tag[reg_wr_rd] = '0;
                end
                if (id_valid && id_dest != 0) begin
                    m_busy[id_dest] = 1'b1; m_tag[id_dest] = id_rob_idx;
                end
            end
            if (commit) m_val[reg_wr_rd] = reg_wr_val;
        end
    endtask

    function automatic logic [RB+32:0] model_read(input logic [4:0] src);
        logic          b;
        logic [RB-1:0] t;
        logic [31:0]   v;
        if (src == 0) return '0;
        b = m_busy[src]; t = m_tag[src]; v = m_val[src];
        if (reg_wr_ena && reg_wr_rd == src) begin
            v = reg_wr_val;
            if (m_tag[src] == reg_wr_idx) begin
                b = 1'b0; t = '0;
            end
        end
        return {b, t, v};
    endfunction

    // Advance one clock: inputs stay stable across the posedge, model follows.
    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [RB+32:0] obs, input logic [RB+32:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic chk1(input string name, input logic eb, input logic [RB-1:0] et, input logic [31:0] ev);
        #1;
        chk(name, {id_src1_busy, id_src1_tag, id_val1}, {eb, et, ev});
    endtask

    task automatic chk_all_zero(input string name);
        for (int i = 0; i < NR; i++) begin
            id_src1 = 5'(i);
            id_src2 = 5'(NR - 1 - i);
            #1;
            chk(name, {id_src1_busy, id_src1_tag, id_val1}, '0);
            chk(name, {id_src2_busy, id_src2_tag, id_val2}, '0);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < NR; i++) begin
            m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
        end
        set_idle();
        id_src1 = '0;
        id_src2 = '0;
        @(negedge clk);

        // Reset state
        rst = 1'b1;
        tick();
        set_idle();
        chk_all_zero("reset_state");

        // Issue then commit with matching tag
        id_valid = 1; id_dest = 5; id_rob_idx = 3;
        tick();
        set_idle(); id_src1 = 5;
        chk1("issue_x5", 1'b1, 4'd3, 32'h0);
        reg_wr_ena = 1; reg_wr_rd = 5; reg_wr_idx = 3; reg_wr_val = 32'hDEADBEEF;
        chk1("fwd_x5", 1'b0, 4'd0, 32'hDEADBEEF);
        tick();
        set_idle();
        chk1("stored_x5", 1'b0, 4'd0, 32'hDEADBEEF);

        // Stale commit leaves the newer rename in place
        id_valid = 1; id_dest = 7; id_rob_idx = 2;
        tick();
        id_rob_idx = 4;
        tick();
        set_idle(); id_src1 = 7;
        reg_wr_ena = 1; reg_wr_rd = 7; reg_wr_idx = 2; reg_wr_val = 32'h11;
        chk1("fwd_stale_x7", 1'b1, 4'd4, 32'h11);
        tick();
        set_idle();
        chk1("stale_commit_x7", 1'b1, 4'd4, 32'h11);
        reg_wr_ena = 1; reg_wr_rd = 7; reg_wr_idx = 4; reg_wr_val = 32'h22;
        tick();
        set_idle();
        chk1("final_commit_x7", 1'b0, 4'd0, 32'h22);

        // Same-cycle rename and commit to one register
        id_valid = 1; id_dest = 9; id_rob_idx = 5;
        tick();
        id_rob_idx = 6;
        reg_wr_ena = 1; reg_wr_rd = 9; reg_wr_idx = 5; reg_wr_val = 32'h99;
        tick();
        set_idle(); id_src1 = 9;
        chk1("rename_wins_x9", 1'b1, 4'd6, 32'h99);

        // Rollback clears every rename but keeps the commit write
        for (int i = 1; i <= 3; i++) begin
            id_valid = 1; id_dest = 5'(i); id_rob_idx = 4'(i);
            tick();
        end
        set_idle();
        rob_rb_ena = 1; reg_wr_ena = 1; reg_wr_rd = 1; reg_wr_idx = 1; reg_wr_val = 32'h1004;
        id_valid = 1; id_dest = 4; id_rob_idx = 7;
        tick();
        set_idle();
        id_src1 = 1; chk1("rb_x1", 1'b0, 4'd0, 32'h1004);
        id_src1 = 2; chk1("rb_x2", 1'b0, 4'd0, 32'h0);
        id_src1 = 3; chk1("rb_x3", 1'b0, 4'd0, 32'h0);
        id_src1 = 4; chk1("rb_x4_not_renamed", 1'b0, 4'd0, 32'h0);
        id_src1 = 9; chk1("rb_x9", 1'b0, 4'd0, 32'h99);

        // x0 is immutable
        id_valid = 1; id_dest = 0; id_rob_idx = 5;
        reg_wr_ena = 1; reg_wr_rd = 0; reg_wr_idx = 5; reg_wr_val = 32'h55;
        id_src1 = 0;
        chk1("x0_fwd", 1'b0, 4'd0, 32'h0);
        tick();
        set_idle();
        chk1("x0_after", 1'b0, 4'd0, 32'h0);

        // Stall holds state
        rdy = 0;
        reg_wr_ena = 1; reg_wr_rd = 5; reg_wr_idx = 0; reg_wr_val = 32'h1234;
        id_valid = 1; id_dest = 6; id_rob_idx = 2;
        tick();
        set_idle();
        id_src1 = 5; chk1("stall_x5", 1'b0, 4'd0, 32'hDEADBEEF);
        id_src1 = 6; chk1("stall_x6", 1'b0, 4'd0, 32'h0);

        // Reset overrides pending issue and commit
        id_valid = 1; id_dest = 5; id_rob_idx = 3;
        tick();
        set_idle();
        rst = 1; reg_wr_ena = 1; reg_wr_rd = 5; reg_wr_idx = 3; reg_wr_val = 32'h77;
        id_valid = 1; id_dest = 8; id_rob_idx = 1;
        tick();
        set_idle();
        chk_all_zero("mid_reset");

        // Random traffic against the model
        for (int c = 0; c < 600; c++) begin
            logic [4:0] r;
            set_idle();
            rst        = ($urandom_range(0, 59) == 0);
            rdy        = ($urandom_range(0, 7) != 0);
            rob_rb_ena = ($urandom_range(0, 24) == 0);
            id_valid   = $urandom_range(0, 1);
            id_dest    = 5'($urandom_range(0, 31));
            id_rob_idx = 4'($urandom_range(1, 15));
            reg_wr_ena = $urandom_range(0, 1);
            r          = 5'($urandom_range(0, 31));
            reg_wr_rd  = r;
            reg_wr_idx = ($urandom_range(0, 2) != 0) ? m_tag[r] : 4'($urandom_range(0, 15));
            reg_wr_val = $urandom;
            id_src1    = ($urandom_range(0, 1) != 0) ? r : 5'($urandom_range(0, 31));
            id_src2    = 5'($urandom_range(0, 31));
            #1;
            chk("rand_src1", {id_src1_busy, id_src1_tag, id_val1}, model_read(id_src1));
            chk("rand_src2", {id_src2_busy, id_src2_tag, id_val2}, model_read(id_src2));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/reg_status_file.md
REG_STATUS_FILE -- requirements
Module: reg_status_file

Interface
REQ-001 SHALL have parameter ROB_BIT, default 4, width of ROB index tags. ROB slots run 1..2^ROB_BIT-1; tag 0 means "no producer".
REQ-002 SHALL have parameter REG_NUM, default 32, number of architectural registers; x0 is hardwired.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on posedge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port rdy, input, 1, global ready; low = stall.
REQ-006 SHALL have port rob_rb_ena, input, 1, rollback pulse from commit.
REQ-007 SHALL have port id_src1 / id_src2, input, 5, decode source register indices.
REQ-008 SHALL have port id_src1_busy / id_src2_busy, output, 1, source awaits a ROB producer.
REQ-009 SHALL have port id_src1_tag / id_src2_tag, output, ROB_BIT, producer ROB index (0 when not busy).
REQ-010 SHALL have port id_val1 / id_val2, output, 32, committed register value (valid when not busy).
REQ-011 SHALL have port id_valid, input, 1, decode issues an instruction this cycle.
REQ-012 SHALL have port id_dest, input, 5, destination register of issuing instruction.
REQ-013 SHALL have port id_rob_idx, input, ROB_BIT, ROB slot allocated to the issuing instruction.
REQ-014 SHALL have port reg_wr_ena, input, 1, commit write enable.
REQ-015 SHALL have port reg_wr_rd, input, 5, commit destination.
REQ-016 SHALL have port reg_wr_val, input, 32, commit value.
REQ-017 SHALL have port reg_wr_idx, input, ROB_BIT, ROB slot being committed.

Function
REQ-018 SHALL hold per register: val[31:0], busy, tag[ROB_BIT-1:0].
REQ-019 SHALL drive read ports combinationally. Forwarding when reg_wr_ena && reg_wr_rd==src && src!=0: val = reg_wr_val. If additionally tag[src]==reg_wr_idx, busy=0 and tag=0.
REQ-020 SHALL otherwise return stored val/busy/tag; reads never see same-cycle renames.
REQ-021 SHALL return val=0, busy=0, tag=0 for src==0 in every case.
REQ-022 SHALL process updates only when rdy=1 and rst=0; rdy=0 holds all state.
REQ-023 SHALL write val[reg_wr_rd] <= reg_wr_val on commit (reg_wr_ena, rd!=0), regardless of tag match.
REQ-024 SHALL clear busy/tag of reg_wr_rd on commit only when tag[rd]==reg_wr_idx; a mismatch leaves the newer rename intact.
REQ-025 SHALL set busy[id_dest]<=1 and tag[id_dest]<=id_rob_idx on issue (id_valid, id_dest!=0, rob_rb_ena=0).
REQ-026 SHALL let the rename win over the commit clear when issue and commit hit the same register in the same cycle; the commit value is still written.
REQ-027 SHALL, on rob_rb_ena=1, clear busy and tag of all registers, still perform that cycle's commit value write, and ignore id_valid.
REQ-028 SHALL never write, rename or mark busy x0.
REQ-029 SHALL have a single always block; no state machine beyond the per-register busy bit (idle/busy per register).

Reset
REQ-030 SHALL, on rst=1 at posedge, set every val=0, busy=0, tag=0. rst overrides rdy, rollback, issue and commit.
REQ-031 SHALL, after reset, read all sources as busy=0, tag=0, val=0.

Verification
REQ-032 Issue x5 with rob_idx 3, then read x5 -> busy=1, tag=3. Commit rd=5, idx=3, val=0xDEADBEEF -> same-cycle read busy=0, val=0xDEADBEEF. Next cycle stored busy=0.
REQ-033 Issue x7 with idx 2, then issue x7 with idx 4. Commit rd=7, idx=2, val=0x11 -> val[7]=0x11, busy=1, tag=4. Commit idx 4 -> busy=0.
REQ-034 In the same cycle, issue x9 with idx 6 and commit rd=9, idx=5 (tag 5 outstanding) -> next cycle busy=1, tag=6, val=commit value.
REQ-035 Issue x1..x3 with idx 1..3, then rollback with commit rd=1, val=0x1004, and id_valid x4 the same cycle -> all busy=0, val[1]=0x1004, x4 not renamed.
REQ-036 Issue/commit to x0 with val 0x55 -> reads of x0 stay 0/not busy. rdy=0 during a commit -> no state change.
REQ-037 Assert rst mid-operation with x5 busy and a pending commit -> next cycle all registers val=0, busy=0.
